// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // Register 0 is hard-wired, so it never counts as a pending write.
  function automatic logic addr_hit(input logic v,
                                    input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] rd);
    return v && (a == rd) && (rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot with valid/ready handshake.
// Writes to register 0 complete the handshake but never load the slot.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  wb_req_t i_req,
  input  logic    i_gnt,
  output logic    o_ready,
  output logic    o_load,
  output logic    o_valid,
  output wb_req_t o_req
);

  logic    r_v;
  wb_req_t r_req;

  assign o_ready = !rst && (!r_v || i_gnt);
  assign o_load  = i_valid && o_ready && (i_req.addr != ZERO_REG);
  assign o_valid = r_v;
  assign o_req   = r_req;

  // Slot storage: load on accepted non-zero write, free on grant unless refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= 1'b0;
      r_req <= '0;
    end else if (o_load) begin
      r_v   <= 1'b1;
      r_req <= i_req;
    end else if (i_gnt) begin
      r_v   <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the register file write port (A3/WD3/WE3).
// Round-robin between slots, oldest-first on same-address writes, registered
// write port, combinational read-address hazard flags.
// Optional macro WB_BYPASS_EN adds forwarding outputs byp_valid1/2, byp_data1/2.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int RR_RESET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [REG_ADDR_W-1:0] req_addr0,
  input  logic [REG_ADDR_W-1:0] req_addr1,
  input  logic [REG_DATA_W-1:0] req_data0,
  input  logic [REG_DATA_W-1:0] req_data1,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [REG_DATA_W-1:0] wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  hazard1,
  output logic                  hazard2
`ifdef WB_BYPASS_EN
  ,
  output logic                  byp_valid1,
  output logic                  byp_valid2,
  output logic [REG_DATA_W-1:0] byp_data1,
  output logic [REG_DATA_W-1:0] byp_data2
`endif
);

  wb_req_t w_in0, w_in1, w_slot0, w_slot1, w_sel;
  logic [1:0] w_slot_v, w_load, w_gnt;
  logic       w_same, w_contest;
  logic [1:0] r_seq;  // 1 = that slot is younger than the other
  logic       r_rr;   // port favoured on the next contested grant
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [REG_DATA_W-1:0] r_wr_data;

  assign w_in0 = '{addr: req_addr0, data: req_data0};
  assign w_in1 = '{addr: req_addr1, data: req_data1};

  wb_slot u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (req_valid[0]),
    .i_req   (w_in0),
    .i_gnt   (w_gnt[0]),
    .o_ready (req_ready[0]),
    .o_load  (w_load[0]),
    .o_valid (w_slot_v[0]),
    .o_req   (w_slot0)
  );

  wb_slot u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (req_valid[1]),
    .i_req   (w_in1),
    .i_gnt   (w_gnt[1]),
    .o_ready (req_ready[1]),
    .o_load  (w_load[1]),
    .o_valid (w_slot_v[1]),
    .o_req   (w_slot1)
  );

  assign w_same = (w_slot0.addr == w_slot1.addr);

  // Grant: single valid slot wins; equal addresses go to the older slot; else round-robin.
  always_comb begin
    w_gnt     = '0;
    w_contest = 1'b0;
    case (w_slot_v)
      2'b01: w_gnt = 2'b01;
      2'b10: w_gnt = 2'b10;
      2'b11: begin
        if (w_same) begin
          w_gnt = r_seq[0] ? 2'b10 : 2'b01;
        end else begin
          w_contest = 1'b1;
          w_gnt     = r_rr ? 2'b10 : 2'b01;
        end
      end
      default: w_gnt = '0;
    endcase
  end

  // Age flags: the most recently loaded slot is younger; port 1 wins a same-edge tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= '0;
    end else begin
      case (w_load)
        2'b01:   r_seq <= 2'b01;
        2'b10:   r_seq <= 2'b10;
        2'b11:   r_seq <= 2'b10;
        default: r_seq <= r_seq;
      endcase
    end
  end

  // Round-robin pointer moves to the other port only after a contested grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= (RR_RESET != 0);
    end else if (w_contest) begin
      r_rr <= w_gnt[0];
    end
  end

  assign w_sel = w_gnt[1] ? w_slot1 : w_slot0;

  // Registered write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (|w_gnt) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= w_sel.addr;
      r_wr_data <= w_sel.data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  assign hazard1 = addr_hit(w_slot_v[0], w_slot0.addr, rd_addr1) ||
                   addr_hit(w_slot_v[1], w_slot1.addr, rd_addr1) ||
                   addr_hit(r_wr_en, r_wr_addr, rd_addr1);
  assign hazard2 = addr_hit(w_slot_v[0], w_slot0.addr, rd_addr2) ||
                   addr_hit(w_slot_v[1], w_slot1.addr, rd_addr2) ||
                   addr_hit(r_wr_en, r_wr_addr, rd_addr2);

`ifdef WB_BYPASS_EN
  wb_req_t w_young, w_old, w_wr;
  logic    w_young_v, w_old_v;

  // Youngest matching write wins: younger slot, then older slot, then write register.
  function automatic logic [REG_DATA_W-1:0] fwd_data(
    input logic [REG_ADDR_W-1:0] rd,
    input logic yv, input wb_req_t y,
    input logic ov, input wb_req_t o,
    input logic wv, input wb_req_t w
  );
    if (addr_hit(yv, y.addr, rd)) return y.data;
    if (addr_hit(ov, o.addr, rd)) return o.data;
    if (addr_hit(wv, w.addr, rd)) return w.data;
    return '0;
  endfunction

  assign w_young   = r_seq[1] ? w_slot1 : w_slot0;
  assign w_young_v = r_seq[1] ? w_slot_v[1] : w_slot_v[0];
  assign w_old     = r_seq[1] ? w_slot0 : w_slot1;
  assign w_old_v   = r_seq[1] ? w_slot_v[0] : w_slot_v[1];
  assign w_wr      = '{addr: r_wr_addr, data: r_wr_data};

  assign byp_valid1 = hazard1;
  assign byp_valid2 = hazard2;
  assign byp_data1  = fwd_data(rd_addr1, w_young_v, w_young, w_old_v, w_old, r_wr_en, w_wr);
  assign byp_data2  = fwd_data(rd_addr2, w_young_v, w_young, w_old_v, w_old, r_wr_en, w_wr);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. Expected register-file writes
// are queued when a handshake is seen and popped when wr_en is observed.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [4:0]  req_addr0, req_addr1;
  logic [31:0] req_data0, req_data1;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        hazard1, hazard2;
`ifdef WB_BYPASS_EN
  logic        byp_valid1, byp_valid2;
  logic [31:0] byp_data1, byp_data2;
`endif

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_wr_data = '0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(2), .RR_RESET(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .hazard1   (hazard1),
    .hazard2   (hazard2)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid1 (byp_valid1),
    .byp_valid2 (byp_valid2),
    .byp_data1  (byp_data1),
    .byp_data2  (byp_data2)
`endif
  );

  // Scoreboard: check each write, then record handshakes (port 0 before port 1).
  always @(negedge clk) begin
    exp_t e;
    if (wr_en === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          bad++;
          $display("FAIL wr_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, e.a, e.d);
        end
      end
      last_wr_data = wr_data;
    end
    if (rst === 1'b0) begin
      if (req_valid[0] && req_ready[0] === 1'b1 && req_addr0 != 5'd0)
        sb.push_back('{a: req_addr0, d: req_data0});
      if (req_valid[1] && req_ready[1] === 1'b1 && req_addr1 != 5'd0)
        sb.push_back('{a: req_addr1, d: req_data1});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0;
    req_addr0 = '0; req_addr1 = '0; req_data0 = '0; req_data1 = '0;
    rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    tick(); tick(); #2;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b required 00", req_ready); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b required 0", wr_en); end
    total++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr: got %0d/%h required 0/0", wr_addr, wr_data); end
    total++; if ({hazard1, hazard2} !== 2'b00) begin bad++; $display("FAIL rst_hazard: got %b required 00", {hazard1, hazard2}); end
    tick(); rst = 1'b0; #2;
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL post_rst_ready: got %b required 11", req_ready); end
  endtask

  task automatic test_single();
    tick();
    req_valid = 2'b01; req_addr0 = 5'd5; req_data0 = 32'h1234_5678;
    rd_addr1 = 5'd5; rd_addr2 = 5'd0; #2;
    total++; if (req_ready[0] !== 1'b1 || hazard1 !== 1'b0) begin bad++; $display("FAIL single_accept: ready0=%b hazard1=%b required 1/0", req_ready[0], hazard1); end
    tick(); req_valid = '0; #2;
    total++; if (hazard1 !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL single_slot: hazard1=%b wr_en=%b required 1/0", hazard1, wr_en); end
    tick(); #2;
    total++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h1234_5678 || hazard1 !== 1'b1) begin
      bad++; $display("FAIL single_write: en=%b addr=%0d data=%h hz=%b required 1/5/12345678/1", wr_en, wr_addr, wr_data, hazard1);
    end
    tick(); #2;
    total++; if (wr_en !== 1'b0 || hazard1 !== 1'b0) begin bad++; $display("FAIL single_done: wr_en=%b hazard1=%b required 0/0", wr_en, hazard1); end
  endtask

  task automatic test_alternate();
    int n0 = 0;
    int n1 = 0;
    logic [1:0] exp_rdy;
    rd_addr1 = '0; rd_addr2 = '0;
    for (int k = 0; k < 40 && (n0 < 10 || n1 < 10); k++) begin
      tick();
      req_valid = {n1 < 10, n0 < 10};
      req_addr0 = 5'd1; req_data0 = 32'h100 + n0;
      req_addr1 = 5'd2; req_data1 = 32'h200 + n1;
      #2;
      if (k >= 1 && k <= 17) begin
        exp_rdy = (k % 2 == 1) ? 2'b01 : 2'b10;
        total++;
        if (req_ready !== exp_rdy) begin bad++; $display("FAIL alt_ready[%0d]: got %b required %b", k, req_ready, exp_rdy); end
      end
      if (req_valid[0] && req_ready[0]) n0++;
      if (req_valid[1] && req_ready[1]) n1++;
    end
    tick(); req_valid = '0;
    total++; if (n0 != 10 || n1 != 10) begin bad++; $display("FAIL alt_accepts: got %0d/%0d required 10/10", n0, n1); end
    for (int w = 0; w < 10 && sb.size() != 0; w++) tick();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL alt_drain: got %0d pending required 0", sb.size()); end
  endtask

  task automatic test_same_addr();
    tick(); rst = 1'b1; req_valid = '0;
    tick(); rst = 1'b0; sb.delete();
    // Contested pair leaves the round-robin pointer on port 1.
    tick(); req_valid = 2'b11; req_addr0 = 5'd12; req_data0 = 32'h12C; req_addr1 = 5'd13; req_data1 = 32'h13D;
    tick(); req_valid = '0;
    tick(); tick(); tick();
    tick(); req_valid = 2'b11; req_addr0 = 5'd7; req_data0 = 32'hA; req_addr1 = 5'd7; req_data1 = 32'hB;
    rd_addr1 = 5'd7; #2;
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL same_ready: got %b required 11", req_ready); end
    tick(); req_valid = '0; #2;
    total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL same_hazard: got %b required 1", hazard1); end
    tick(); #2;
    total++; if (wr_en !== 1'b1 || wr_data !== 32'hA) begin bad++; $display("FAIL same_first: en=%b data=%h required 1/a", wr_en, wr_data); end
    tick(); #2;
    total++; if (wr_en !== 1'b1 || wr_data !== 32'hB) begin bad++; $display("FAIL same_second: en=%b data=%h required 1/b", wr_en, wr_data); end
    tick(); tick();
    total++; if (last_wr_data !== 32'hB || sb.size() != 0 || hazard1 !== 1'b0) begin
      bad++; $display("FAIL same_final: last=%h pending=%0d hz=%b required b/0/0", last_wr_data, sb.size(), hazard1);
    end
  endtask

  task automatic test_r0();
    tick(); req_valid = 2'b10; req_addr1 = 5'd0; req_data1 = 32'hFFFF_FFFF;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0; #2;
    total++; if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL r0_ready: got %b required 1", req_ready[1]); end
    tick(); req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (wr_en !== 1'b0 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
        bad++; $display("FAIL r0_quiet[%0d]: en=%b hz=%b%b required 0/00", i, wr_en, hazard1, hazard2);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    tick(); req_valid = 2'b11; req_addr0 = 5'd3; req_data0 = 32'h33; req_addr1 = 5'd4; req_data1 = 32'h44;
    rd_addr1 = 5'd3; rd_addr2 = 5'd4;
    tick(); req_valid = '0; rst = 1'b1; #2;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL mid_rst_ready: got %b required 00", req_ready); end
    tick(); rst = 1'b0; sb.delete(); #2;
    total++; if (req_ready !== 2'b11 || {hazard1, hazard2} !== 2'b00) begin
      bad++; $display("FAIL mid_rst_after: ready=%b hz=%b%b required 11/00", req_ready, hazard1, hazard2);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr[%0d]: got %b required 0", i, wr_en); end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    tick(); req_valid = 2'b01; req_addr0 = 5'd3; req_data0 = 32'h11; rd_addr1 = 5'd3; rd_addr2 = 5'd0;
    tick(); req_data0 = 32'h22; #2;
    total++; if (req_ready[0] !== 1'b1 || byp_data1 !== 32'h11) begin bad++; $display("FAIL byp_slot: ready0=%b data=%h required 1/11", req_ready[0], byp_data1); end
    tick(); req_valid = '0; #2;
    total++; if (byp_valid1 !== 1'b1 || byp_data1 !== 32'h22 || wr_data !== 32'h11) begin
      bad++; $display("FAIL byp_young: v=%b data=%h wr=%h required 1/22/11", byp_valid1, byp_data1, wr_data);
    end
    tick(); #2;
    total++; if (byp_data1 !== 32'h22) begin bad++; $display("FAIL byp_wr: got %h required 22", byp_data1); end
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_same_addr();
    test_r0();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    total++; if (sb.size() != 0) begin bad++; $display("FAIL end_pending: got %0d required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port (A3/WD3/WE3) between two writeback requesters: port 0 (ALU result) and port 1 (memory load). Each port has a one-entry holding slot with a valid/ready handshake. A round-robin arbiter, which preserves ordering on same-address writes, drives a registered write port into the register file. The block also reports pending-write hazards for the two register-file read addresses.

## Interface
Parameters:
- NREQ, 2, number of requester ports (fixed; only 2 supported)
- RR_RESET, 0, requester given priority first after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  2  per-port write request valid
- req_ready  out  2  per-port accept; a transfer occurs when valid & ready at the clk edge
- req_addr0, req_addr1  in  5  destination register per port
- req_data0, req_data1  in  32  write data per port
- wr_en  out  1  to register file WE3 (registered)
- wr_addr  out  5  to register file A3 (registered)
- wr_data  out  32  to register file WD3 (registered)
- rd_addr1, rd_addr2  in  5  current register-file read addresses (A1, A2)
- hazard1, hazard2  out  1  high when the read address has a write in flight
- byp_valid1/2, byp_data1/2  out  1/32  forwarding outputs; present only with WB_BYPASS_EN

## Operation
- Slot state per port: slot_v, slot_addr, slot_data, slot_seq. slot_seq is a 1-bit age flag: 1 means younger than the other slot.
- req_ready[i] = !rst && (!slot_v[i] || gnt[i]). A freed slot can be refilled on the same edge it is granted.
- Writes to register 0 complete the handshake normally and are then discarded. They never load a slot and never produce wr_en.
- Both ports accepted on the same edge: port 1 counts as younger.
- Arbitration is combinational over valid slots:
  - One valid slot: grant it.
  - Both valid, addresses equal: grant the older slot (ordering is mandatory).
  - Both valid, addresses differ: grant the port indicated by the round-robin pointer. The pointer then moves to the other port.
  - The pointer updates only on a contested grant.
- On a grant, register wr_en=1, wr_addr=slot_addr and wr_data=slot_data; clear slot_v unless the slot is refilled on the same edge. With no grant, register wr_en=0 and hold wr_addr and wr_data.
- hazard_k is high when rd_addr_k != 0 and rd_addr_k matches any valid slot, or matches wr_addr while wr_en=1.
- Reset values:
  - slot_v=0, slot_seq=0
  - rr pointer = RR_RESET
  - wr_en=0, wr_addr=0, wr_data=0
  - req_ready=0 while rst is high
  - hazard=0; byp_valid=0 and byp_data=0 as outputs settle after reset
- rst asserted mid-operation drops all held writes; no write is issued after reset.

## Timing
- Accept at edge E0, slot valid during the next cycle, grant at edge E1, wr_en high during the next cycle, register file writes at edge E2. Uncontested latency is 2 cycles from accept to register-file update.
- Throughput is one write per cycle total. With both ports continuously valid, grants alternate 0,1,0,1… and each port sees ready every other cycle.
- hazard and byp outputs are combinational from registered state and rd_addr (same cycle).

## Configuration
- WB_BYPASS_EN defined:
  - Adds byp_valid1/2 and byp_data1/2.
  - byp_valid_k mirrors hazard_k. byp_data_k is the data of the youngest matching in-flight write, searched youngest slot first, then older slot, then the output register.
  - hazard outputs remain.
- Undefined: byp ports and forwarding muxes are absent; hazard only, and the consumer must stall.

## Structure
- Shared package regfile_pkg holds REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=5'd0, and a packed wb_req_t {addr, data}.
- One natural sub-module, wb_slot: a single holding slot with its handshake, instantiated twice.
- Arbiter, age tracking, output register and hazard/bypass logic are in the top.

## Test plan
- Port 0 writes r5=0x1234_5678 alone: wr_en high 2 cycles after accept with wr_addr=5 and wr_data=0x12345678; hazard1 high while rd_addr1=5 during those 2 cycles.
- Both ports valid every cycle, r1 on port 0 and r2 on port 1: grants alternate starting with port 0; each port's ready toggles; no write is lost over 20 requests.
- Same edge, port 0 r7=0xA and port 1 r7=0xB: wr sequence is 0xA then 0xB; final r7=0xB.
- Port 1 writes r0=0xFFFF_FFFF: handshake completes, wr_en stays 0, hazard stays 0 with rd_addr=0.
- Two writes held, rst pulsed 1 cycle: slots cleared, wr_en=0 thereafter, req_ready=0 during rst and 1 after.
- WB_BYPASS_EN, slot holds r3=0x22 and output register holds r3=0x11: byp_data1=0x22 with rd_addr1=3.
